// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder with registered sum, carry out and group G/P.
// Lookahead tree: 8 blocks of 4 bits -> 2 groups of 16 bits -> 32 bits.
module cla_adder_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        c_in,
   output logic        G,
   output logic        P,
   output logic        c32,
   output logic [31:0] sum
);

   localparam int unsigned W      = 32;
   localparam int unsigned NBLK   = 8;
   localparam int unsigned NGRP   = 2;

   logic [W-1:0]    g, p, c;
   logic [NBLK-1:0] gg, pp, cb;
   logic [NGRP-1:0] g16, p16;
   logic            c16;
   logic            g_c, p_c, c32_c;
   logic [W-1:0]    sum_c;

   // Bit generate/propagate; XOR propagate is shared with the sum bit.
   assign g = x & y;
   assign p = x ^ y;

   genvar k, j;

   // 4-bit blocks: group G/P plus two-level carries from the block carry-in.
   for (k = 0; k < NBLK; k++) begin : g_blk
      assign gg[k] = g[4*k+3]
                   | (p[4*k+3] & g[4*k+2])
                   | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign pp[k] = &p[4*k +: 4];

      assign c[4*k]   = cb[k];
      assign c[4*k+1] = g[4*k] | (p[4*k] & cb[k]);
      assign c[4*k+2] = g[4*k+1]
                      | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & cb[k]);
      assign c[4*k+3] = g[4*k+2]
                      | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
   end

   // 16-bit groups: block carry-ins and the group G/P from four block pairs.
   for (j = 0; j < NGRP; j++) begin : g_grp
      logic cin_grp;
      assign cin_grp = (j == 0) ? c_in : c16;

      assign g16[j] = gg[4*j+3]
                    | (pp[4*j+3] & gg[4*j+2])
                    | (pp[4*j+3] & pp[4*j+2] & gg[4*j+1])
                    | (pp[4*j+3] & pp[4*j+2] & pp[4*j+1] & gg[4*j]);
      assign p16[j] = &pp[4*j +: 4];

      assign cb[4*j]   = cin_grp;
      assign cb[4*j+1] = gg[4*j] | (pp[4*j] & cin_grp);
      assign cb[4*j+2] = gg[4*j+1]
                       | (pp[4*j+1] & gg[4*j])
                       | (pp[4*j+1] & pp[4*j] & cin_grp);
      assign cb[4*j+3] = gg[4*j+2]
                       | (pp[4*j+2] & gg[4*j+1])
                       | (pp[4*j+2] & pp[4*j+1] & gg[4*j])
                       | (pp[4*j+2] & pp[4*j+1] & pp[4*j] & cin_grp);
   end

   // Top level: carry into the upper group and the 32-bit G/P/carry out.
   assign c16   = g16[0] | (p16[0] & c_in);
   assign g_c   = g16[1] | (p16[1] & g16[0]);
   assign p_c   = p16[1] & p16[0];
   assign c32_c = g_c | (p_c & c_in);
   assign sum_c = p ^ c;

   // Output register; reset wins over new operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
         c32 <= 1'b0;
         G   <= 1'b0;
         P   <= 1'b0;
      end else begin
         sum <= sum_c;
         c32 <= c32_c;
         G   <= g_c;
         P   <= p_c;
      end
   end

endmodule

// File: tb/tb_cla_adder_32.sv
// Self-checking bench for cla_adder_32 against an arithmetic reference model.
module tb_cla_adder_32;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x, y;
   logic        c_in;
   logic        G, P, c32;
   logic [31:0] sum;

   int checks   = 0;
   int failures = 0;

   cla_adder_32 dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x),
      .y    (y),
      .c_in (c_in),
      .G    (G),
      .P    (P),
      .c32  (c32),
      .sum  (sum)
   );

   always #5 clk = ~clk;

   // Reference: plain 33-bit arithmetic; returns {G, P, c32, sum}.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci);
      logic [32:0] full, nocin;
      logic        gen, prop;
      full  = {1'b0, a} + {1'b0, b} + 33'(ci);
      nocin = {1'b0, a} + {1'b0, b};
      gen   = nocin[32];
      prop  = ((a ^ b) == 32'hFFFF_FFFF);
      return {gen, prop, full};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [34:0] got;
      rst = 1'b1; x = 32'hFFFF_FFFF; y = 32'h1; c_in = 1'b0;
      tick(); tick();
      got = {G, P, c32, sum};
      checks++;
      if (got !== 35'h0) begin
         failures++;
         $display("FAIL reset_hold: got G=%b P=%b c32=%b sum=%h expected all zero", G, P, c32, sum);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (got === 35'h0 && {G, P, c32, sum} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL reset_release: got G=%b P=%b c32=%b sum=%h expected G=1 P=0 c32=1 sum=0",
                  G, P, c32, sum);
      end else if (got !== 35'h0) begin
         failures++;
         $display("FAIL reset_release: preceding hold state wrong");
      end
   endtask

   task automatic test_reset_priority();
      x = 32'h1234_5678; y = 32'h8765_4321; c_in = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({G, P, c32, sum} !== 35'h0) begin
         failures++;
         $display("FAIL reset_priority: got G=%b P=%b c32=%b sum=%h expected all zero", G, P, c32, sum);
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      x = 32'h0000_0001; y = 32'hFFFF_FFFF; c_in = 1'b0;
      for (int i = 0; i < 22; i++) begin
         tick();
         checks++;
         if ({G, P, c32, sum} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wrap_cycle%0d: got G=%b P=%b c32=%b sum=%h expected G=1 P=0 c32=1 sum=0",
                     i, G, P, c32, sum);
         end
      end
   endtask

   task automatic test_propagate();
      x = 32'hAAAA_AAAA; y = 32'h5555_5555; c_in = 1'b0;
      tick();
      checks++;
      if ({G, P, c32, sum} !== {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
         failures++;
         $display("FAIL propagate_cin0: got G=%b P=%b c32=%b sum=%h expected G=0 P=1 c32=0 sum=ffffffff",
                  G, P, c32, sum);
      end
      c_in = 1'b1;
      tick();
      checks++;
      if ({G, P, c32, sum} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL propagate_cin1: got G=%b P=%b c32=%b sum=%h expected G=0 P=1 c32=1 sum=0",
                  G, P, c32, sum);
      end
   endtask

   task automatic test_boundary();
      x = 32'h0000_FFFF; y = 32'h0000_0001; c_in = 1'b0;
      tick();
      checks++;
      if ({G, P, c32, sum} !== {1'b0, 1'b0, 1'b0, 32'h0001_0000}) begin
         failures++;
         $display("FAIL boundary_16: got G=%b P=%b c32=%b sum=%h expected G=0 P=0 c32=0 sum=00010000",
                  G, P, c32, sum);
      end
      x = 32'h0FFF_FFFF; y = 32'h0; c_in = 1'b1;
      tick();
      checks++;
      if ({c32, sum} !== {1'b0, 32'h1000_0000}) begin
         failures++;
         $display("FAIL boundary_28: got c32=%b sum=%h expected c32=0 sum=10000000", c32, sum);
      end
      // Carry chained through every block boundary from c_in.
      x = 32'hFFFF_FFFF; y = 32'h0; c_in = 1'b1;
      tick();
      checks++;
      if ({G, P, c32, sum} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL boundary_all: got G=%b P=%b c32=%b sum=%h expected G=0 P=1 c32=1 sum=0",
                  G, P, c32, sum);
      end
   endtask

   task automatic test_back_to_back();
      x = 32'h1; y = 32'h2; c_in = 1'b0;
      tick();
      x = 32'h7FFF_FFFF; y = 32'h1; c_in = 1'b0;
      checks++;
      if ({c32, sum} !== {1'b0, 32'h3}) begin
         failures++;
         $display("FAIL b2b_0: got c32=%b sum=%h expected c32=0 sum=00000003", c32, sum);
      end
      tick();
      x = 32'h8000_0000; y = 32'h8000_0000; c_in = 1'b1;
      checks++;
      if ({c32, sum} !== {1'b0, 32'h8000_0000}) begin
         failures++;
         $display("FAIL b2b_1: got c32=%b sum=%h expected c32=0 sum=80000000", c32, sum);
      end
      tick();
      checks++;
      if ({G, c32, sum} !== {1'b1, 1'b1, 32'h1}) begin
         failures++;
         $display("FAIL b2b_2: got G=%b c32=%b sum=%h expected G=1 c32=1 sum=00000001", G, c32, sum);
      end
   endtask

   task automatic test_random();
      logic [34:0] exp_v;
      int          shown = 0;
      for (int i = 0; i < 10000; i++) begin
         x    = $urandom();
         y    = (i % 16 == 3) ? ~x : 32'($urandom());
         c_in = 1'($urandom_range(0, 1));
         exp_v = model(x, y, c_in);
         tick();
         checks++;
         if ({c32, sum} !== exp_v[32:0]) begin
            failures++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random_sum%0d: got c32=%b sum=%h expected c32=%b sum=%h",
                        i, c32, sum, exp_v[32], exp_v[31:0]);
            end
         end
         checks++;
         if ({G, P} !== exp_v[34:33]) begin
            failures++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random_gp%0d: got G=%b P=%b expected G=%b P=%b",
                        i, G, P, exp_v[34], exp_v[33]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; x = '0; y = '0; c_in = 1'b0;
      test_reset();
      test_wrap();
      test_propagate();
      test_boundary();
      test_back_to_back();
      test_reset_priority();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
